// File: rtl/sik_pkg.sv
// sik_pkg -- shared definitions for the SIK instruction encoder.
//   Opcode constants (normal and extended), PRE/NOARG nibbles, word and
//   immediate widths, encoder FSM state encoding and the request struct.
package sik_pkg;

    localparam int WORD_W   = 16;
    localparam int IMM_W    = 16;
    localparam int OP_W     = 4;
    localparam int IMM_LO_W = 12;

    localparam logic [OP_W-1:0] NIB_PRE   = 4'hF;
    localparam logic [OP_W-1:0] NIB_NOARG = 4'h0;

    // Normal (immediate-carrying) opcodes; 1..8 are the defined set.
    localparam logic [OP_W-1:0] OP_LOAD   = 4'h1;
    localparam logic [OP_W-1:0] OP_STORE  = 4'h2;
    localparam logic [OP_W-1:0] OP_JZ     = 4'h3;
    localparam logic [OP_W-1:0] OP_JNZ    = 4'h4;
    localparam logic [OP_W-1:0] OP_CALL   = 4'h5;
    localparam logic [OP_W-1:0] OP_JMP    = 4'h6;
    localparam logic [OP_W-1:0] OP_LIT    = 4'h7;
    localparam logic [OP_W-1:0] OP_PUSH   = 4'h8;
    localparam logic [OP_W-1:0] NRM_OP_MAX = OP_PUSH;

    // Extended (no-argument) opcodes; 1..C are the defined set.
    localparam logic [OP_W-1:0] EXT_ADD   = 4'h1;
    localparam logic [OP_W-1:0] EXT_AND   = 4'h2;
    localparam logic [OP_W-1:0] EXT_SUB   = 4'h3;
    localparam logic [OP_W-1:0] EXT_RET   = 4'hC;
    localparam logic [OP_W-1:0] EXT_OP_MAX = EXT_RET;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRE_OUT = 2'd1,
        OP_OUT  = 2'd2
    } sik_state_e;

    typedef struct packed {
        logic             ext;
        logic [OP_W-1:0]  op;
        logic [IMM_W-1:0] imm;
    } sik_req_t;

    // PRE word carries the top immediate nibble in its low bits.
    function automatic logic [WORD_W-1:0] mk_pre_word(input logic [OP_W-1:0] hi);
        return {NIB_PRE, {(WORD_W-2*OP_W){1'b0}}, hi};
    endfunction

endpackage

// File: rtl/sik_encode_if.sv
// sik_encode_if -- request handshake plus memory write port of the encoder.
//   in_valid/in_ready/in_ext/in_op/in_imm : symbolic request channel
//   wr_en/wr_addr/wr_data/out_ready       : instruction memory write port
//   slave  : encoder side
//   master : requester / memory side
import sik_pkg::*;

interface sik_encode_if;
    logic              in_valid;
    logic              in_ready;
    logic              in_ext;
    logic [OP_W-1:0]   in_op;
    logic [IMM_W-1:0]  in_imm;
    logic              wr_en;
    logic [WORD_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              out_ready;

    modport slave (
        input  in_valid, in_ext, in_op, in_imm, out_ready,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_valid, in_ext, in_op, in_imm, out_ready,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/sik_word_pack.sv
// sik_word_pack -- combinational packer for one SIK request.
//   req      : ext flag, opcode nibble, 16-bit immediate
//   op_word  : the opcode word
//   pre_word : PRE word holding imm[15:12]
//   need_pre : a PRE word must precede op_word
//   illegal  : request is outside the defined opcode set
//              (only when SIK_OPCHECK_EN is defined, otherwise 0)
import sik_pkg::*;

module sik_word_pack (
    input  sik_req_t          req,
    output logic [WORD_W-1:0] op_word,
    output logic [WORD_W-1:0] pre_word,
    output logic              need_pre,
    output logic              illegal
);

    always_comb begin
        op_word  = req.ext ? {{(WORD_W-OP_W){1'b0}}, req.op}
                           : {req.op, req.imm[IMM_LO_W-1:0]};
        pre_word = mk_pre_word(req.imm[IMM_W-1:IMM_LO_W]);
        // Extended ops never carry an immediate, so never need PRE.
        need_pre = ~req.ext & (req.imm[IMM_W-1:IMM_LO_W] != NIB_NOARG);
`ifdef SIK_OPCHECK_EN
        if (req.ext)
            illegal = (req.op == NIB_NOARG) || (req.op > EXT_OP_MAX);
        else
            illegal = (req.op == NIB_NOARG) || (req.op > NRM_OP_MAX);
`else
        illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/sik_encode.sv
// sik_encode -- SIK instruction encoder / instruction memory filler.
//   Accepts symbolic requests, packs them into one or two 16-bit words
//   (PRE + op when the immediate exceeds 12 bits) and streams them to a
//   memory write port at auto-incrementing addresses.
// Ports:
//   clk, reset (async, active low)
//   bus         : sik_encode_if.slave (request channel + write port)
//   base_load   : load the write address from base_addr (IDLE, no accept)
//   base_addr   : new write address
//   emitted_cnt : words written so far, wraps at 2^16
//   err         : one-cycle illegal-request pulse
// Optional feature macro: SIK_OPCHECK_EN (opcode legality checking + err).
import sik_pkg::*;

module sik_encode #(
    parameter logic [WORD_W-1:0] ADDR_STEP  = 16'd1,
    parameter logic [WORD_W-1:0] RESET_ADDR = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    sik_encode_if.slave       bus,
    input  logic              base_load,
    input  logic [WORD_W-1:0] base_addr,
    output logic [WORD_W-1:0] emitted_cnt,
    output logic              err
);

    sik_state_e        state;
    sik_req_t          req;
    logic [WORD_W-1:0] op_word, pre_word, op_lat;
    logic [WORD_W-1:0] wr_addr_q, wr_data_q, cnt_q;
    logic              need_pre, illegal;
    logic              wr_en_q, in_ready_c, acc, emit;

    assign req = {bus.in_ext, bus.in_op, bus.in_imm};

    sik_word_pack u_pack (
        .req      (req),
        .op_word  (op_word),
        .pre_word (pre_word),
        .need_pre (need_pre),
        .illegal  (illegal)
    );

    // A new request can ride in on the same edge the op word leaves.
    always_comb begin
        in_ready_c = 1'b0;
        case (state)
            IDLE:    in_ready_c = 1'b1;
            PRE_OUT: in_ready_c = 1'b0;
            OP_OUT:  in_ready_c = bus.out_ready;
            default: in_ready_c = 1'b0;
        endcase
    end

    assign acc  = bus.in_valid & in_ready_c;
    assign emit = wr_en_q & bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= RESET_ADDR;
            cnt_q     <= '0;
            op_lat    <= '0;
        end else begin
            if (emit) begin
                wr_addr_q <= wr_addr_q + ADDR_STEP;
                cnt_q     <= cnt_q + 16'd1;
            end

            if (state == PRE_OUT) begin
                if (bus.out_ready) begin
                    state     <= OP_OUT;
                    wr_data_q <= op_lat;
                end
            end else if (acc) begin
                if (illegal) begin
                    // Handshake completes but nothing is written.
                    state   <= IDLE;
                    wr_en_q <= 1'b0;
                end else if (need_pre) begin
                    state     <= PRE_OUT;
                    wr_en_q   <= 1'b1;
                    wr_data_q <= pre_word;
                    op_lat    <= op_word;
                end else begin
                    state     <= OP_OUT;
                    wr_en_q   <= 1'b1;
                    wr_data_q <= op_word;
                end
            end else if (state == OP_OUT) begin
                if (bus.out_ready) begin
                    state   <= IDLE;
                    wr_en_q <= 1'b0;
                end
            end else if (base_load) begin
                // Only reachable in IDLE without an accept, so no clash
                // with the address increment above.
                wr_addr_q <= base_addr;
            end
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign emitted_cnt  = cnt_q;

`ifdef SIK_OPCHECK_EN
    logic err_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= acc & illegal;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sik_encode.sv
// tb_sik_encode -- self-checking bench for sik_encode.
//   Directed scenarios plus randomized traffic compared with a word-stream
//   model built directly from the encoding rules.
module tb_sik_encode;

`ifdef SIK_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        base_load;
    logic [15:0] base_addr;
    logic [15:0] emitted_cnt;
    logic        err;

    sik_encode_if ifc ();

    sik_encode dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (ifc),
        .base_load   (base_load),
        .base_addr   (base_addr),
        .emitted_cnt (emitted_cnt),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: expected {addr,data} stream and err count.
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [15:0] m_addr;
    int          exp_err;
    int          err_obs;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ifc.wr_en === 1'b1 && ifc.out_ready === 1'b1)
                obs_q.push_back({ifc.wr_addr, ifc.wr_data});
            if (err === 1'b1) err_obs++;
        end
    end

    function automatic bit m_illegal(bit ext, logic [3:0] op);
        if (!OPCHECK) return 1'b0;
        if (op == 4'h0) return 1'b1;
        return ext ? (op > 4'hC) : (op > 4'h8);
    endfunction

    function automatic void model_push(bit ext, logic [3:0] op, logic [15:0] imm);
        int hi = int'(imm) / 4096;
        int lo = int'(imm) % 4096;
        if (m_illegal(ext, op)) begin
            exp_err++;
            return;
        end
        if (ext) begin
            exp_q.push_back({m_addr, 16'(int'(op))});
            m_addr = m_addr + 16'd1;
        end else begin
            if (hi != 0) begin
                exp_q.push_back({m_addr, 16'(61440 + hi)});
                m_addr = m_addr + 16'd1;
            end
            exp_q.push_back({m_addr, 16'(int'(op) * 4096 + lo)});
            m_addr = m_addr + 16'd1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.in_valid  = 1'b0;
        ifc.in_ext    = 1'b0;
        ifc.in_op     = 4'h0;
        ifc.in_imm    = 16'h0000;
        ifc.out_ready = 1'b1;
        base_load     = 1'b0;
        base_addr     = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic push(bit ext, logic [3:0] op, logic [15:0] imm);
        ifc.in_valid = 1'b1;
        ifc.in_ext   = ext;
        ifc.in_op    = op;
        ifc.in_imm   = imm;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ifc.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", ifc.wr_en); end
        checks++; if (ifc.wr_addr !== 16'h0000) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0000", ifc.wr_addr); end
        checks++; if (ifc.wr_data !== 16'h0000) begin failures++; $display("FAIL reset_wr_data got=%h exp=0000", ifc.wr_data); end
        checks++; if (emitted_cnt !== 16'h0000) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", emitted_cnt); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ifc.in_ready); end
    endtask

    task automatic test_short_imm();
        do_reset();
        push(1'b0, 4'h8, 16'h0123);
        step();
        ifc.in_valid = 1'b0;
        checks++; if (ifc.wr_en !== 1'b1) begin failures++; $display("FAIL short_wr_en got=%b exp=1", ifc.wr_en); end
        checks++; if (ifc.wr_addr !== 16'h0000) begin failures++; $display("FAIL short_addr got=%h exp=0000", ifc.wr_addr); end
        checks++; if (ifc.wr_data !== 16'h8123) begin failures++; $display("FAIL short_data got=%h exp=8123", ifc.wr_data); end
        step();
        checks++; if (ifc.wr_en !== 1'b0) begin failures++; $display("FAIL short_idle_wr_en got=%b exp=0", ifc.wr_en); end
        checks++; if (emitted_cnt !== 16'd1) begin failures++; $display("FAIL short_cnt got=%0d exp=1", emitted_cnt); end
    endtask

    task automatic test_long_imm();
        do_reset();
        push(1'b0, 4'h8, 16'hABCD);
        step();
        ifc.in_valid = 1'b0;
        checks++; if (ifc.wr_data !== 16'hF00A || ifc.wr_addr !== 16'h0000) begin failures++; $display("FAIL pre_word got=%h@%h exp=F00A@0000", ifc.wr_data, ifc.wr_addr); end
        checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL pre_in_ready got=%b exp=0", ifc.in_ready); end
        step();
        checks++; if (ifc.wr_en !== 1'b1 || ifc.wr_data !== 16'h8BCD || ifc.wr_addr !== 16'h0001) begin failures++; $display("FAIL pre_op_word got=%b %h@%h exp=1 8BCD@0001", ifc.wr_en, ifc.wr_data, ifc.wr_addr); end
        step();
        checks++; if (ifc.wr_en !== 1'b0 || emitted_cnt !== 16'd2) begin failures++; $display("FAIL pre_done got=%b cnt=%0d exp=0 cnt=2", ifc.wr_en, emitted_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(1'b1, 4'h1, 16'hFFFF);
        step();
        ifc.in_op = 4'h3;
        checks++; if (ifc.wr_data !== 16'h0001 || ifc.wr_addr !== 16'h0000) begin failures++; $display("FAIL b2b_first got=%h@%h exp=0001@0000", ifc.wr_data, ifc.wr_addr); end
        step();
        ifc.in_valid = 1'b0;
        checks++; if (ifc.wr_en !== 1'b1 || ifc.wr_data !== 16'h0003 || ifc.wr_addr !== 16'h0001) begin failures++; $display("FAIL b2b_second got=%b %h@%h exp=1 0003@0001", ifc.wr_en, ifc.wr_data, ifc.wr_addr); end
        step();
        checks++; if (ifc.wr_en !== 1'b0 || emitted_cnt !== 16'd2) begin failures++; $display("FAIL b2b_done got=%b cnt=%0d exp=0 cnt=2", ifc.wr_en, emitted_cnt); end
    endtask

    task automatic test_wrap_backpressure();
        do_reset();
        base_load = 1'b1;
        base_addr = 16'hFFFF;
        step();
        base_load = 1'b0;
        checks++; if (ifc.wr_addr !== 16'hFFFF || ifc.wr_en !== 1'b0) begin failures++; $display("FAIL base_load got=%h en=%b exp=FFFF en=0", ifc.wr_addr, ifc.wr_en); end
        push(1'b0, 4'h6, 16'h2005);
        ifc.out_ready = 1'b0;
        step();
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ifc.wr_en !== 1'b1 || ifc.wr_data !== 16'hF002 || ifc.wr_addr !== 16'hFFFF) begin failures++; $display("FAIL stall_hold%0d got=%b %h@%h exp=1 F002@FFFF", i, ifc.wr_en, ifc.wr_data, ifc.wr_addr); end
            if (i < 2) step();
        end
        ifc.out_ready = 1'b1;
        step();
        checks++; if (ifc.wr_data !== 16'h6005 || ifc.wr_addr !== 16'h0000) begin failures++; $display("FAIL wrap_op got=%h@%h exp=6005@0000", ifc.wr_data, ifc.wr_addr); end
        step();
        checks++; if (ifc.wr_en !== 1'b0 || ifc.wr_addr !== 16'h0001 || emitted_cnt !== 16'd2) begin failures++; $display("FAIL wrap_done got=%b %h cnt=%0d exp=0 0001 cnt=2", ifc.wr_en, ifc.wr_addr, emitted_cnt); end
    endtask

    // Continues from the state left by test_wrap_backpressure (IDLE, addr 0001).
    task automatic test_base_collide();
        base_load = 1'b1;
        base_addr = 16'h1234;
        push(1'b1, 4'h2, 16'h0000);
        ifc.out_ready = 1'b0;
        step();
        ifc.in_valid = 1'b0;
        base_addr = 16'h5555;
        checks++; if (ifc.wr_addr !== 16'h0001 || ifc.wr_data !== 16'h0002) begin failures++; $display("FAIL collide_accept got=%h@%h exp=0002@0001", ifc.wr_data, ifc.wr_addr); end
        step();
        checks++; if (ifc.wr_addr !== 16'h0001 || ifc.wr_en !== 1'b1) begin failures++; $display("FAIL base_in_op got=%h en=%b exp=0001 en=1", ifc.wr_addr, ifc.wr_en); end
        base_load = 1'b0;
        ifc.out_ready = 1'b1;
        step();
        checks++; if (ifc.wr_en !== 1'b0 || ifc.wr_addr !== 16'h0002 || emitted_cnt !== 16'd3) begin failures++; $display("FAIL collide_done got=%b %h cnt=%0d exp=0 0002 cnt=3", ifc.wr_en, ifc.wr_addr, emitted_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(1'b0, 4'h8, 16'hABCD);
        step();
        ifc.in_valid = 1'b0;
        checks++; if (ifc.wr_en !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b exp=1", ifc.wr_en); end
        reset = 1'b0;
        #1;
        checks++; if (ifc.wr_en !== 1'b0 || ifc.wr_addr !== 16'h0000 || emitted_cnt !== 16'h0000 || ifc.wr_data !== 16'h0000) begin failures++; $display("FAIL midrst_async got=%b %h@%h cnt=%0d exp=0 0000@0000 cnt=0", ifc.wr_en, ifc.wr_data, ifc.wr_addr, emitted_cnt); end
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ifc.wr_en !== 1'b0 || emitted_cnt !== 16'd0) begin failures++; $display("FAIL midrst_discard%0d got=%b cnt=%0d exp=0 cnt=0", i, ifc.wr_en, emitted_cnt); end
        end
    endtask

`ifdef SIK_OPCHECK_EN
    task automatic test_opcheck();
        do_reset();
        push(1'b1, 4'hD, 16'h0000);
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL ill_ready got=%b exp=1", ifc.in_ready); end
        step();
        ifc.in_valid = 1'b0;
        checks++; if (err !== 1'b1 || ifc.wr_en !== 1'b0 || emitted_cnt !== 16'd0) begin failures++; $display("FAIL ill_pulse got=err%b en%b cnt=%0d exp=err1 en0 cnt=0", err, ifc.wr_en, emitted_cnt); end
        step();
        checks++; if (err !== 1'b0 || ifc.wr_en !== 1'b0) begin failures++; $display("FAIL ill_one_cycle got=err%b en%b exp=err0 en0", err, ifc.wr_en); end
    endtask
`endif

    task automatic test_random();
        int          n_req = 0;
        int          cyc   = 0;
        logic        acc;
        logic [15:0] base;
        do_reset();
        base = 16'hFFF0 + 16'($urandom_range(0, 8));
        base_load = 1'b1;
        base_addr = base;
        step();
        base_load = 1'b0;
        exp_q.delete();
        obs_q.delete();
        exp_err = 0;
        err_obs = 0;
        m_addr  = base;
        mon_en  = 1'b1;
        while (n_req < 150 && cyc < 4000) begin
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            if (!ifc.in_valid && $urandom_range(0, 3) != 0) begin
                ifc.in_valid = 1'b1;
                ifc.in_ext   = 1'($urandom_range(0, 1));
                ifc.in_op    = 4'($urandom_range(0, 15));
                ifc.in_imm   = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 4095));
            end
            @(negedge clk);
            acc = ifc.in_valid && ifc.in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                model_push(ifc.in_ext, ifc.in_op, ifc.in_imm);
                n_req++;
                ifc.in_valid = 1'b0;
            end
        end
        checks++; if (n_req != 150) begin failures++; $display("FAIL rnd_timeout got=%0d exp=150 requests", n_req); end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 10 && ifc.wr_en === 1'b1; i++) step();
        step();
        mon_en = 1'b0;
        checks++; if (ifc.wr_en !== 1'b0) begin failures++; $display("FAIL rnd_drain got=%b exp=0", ifc.wr_en); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_words got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_word%0d got=%h@%h exp=%h@%h", i, obs_q[i][15:0], obs_q[i][31:16], exp_q[i][15:0], exp_q[i][31:16]); end
        end
        checks++; if (emitted_cnt !== 16'(exp_q.size())) begin failures++; $display("FAIL rnd_cnt got=%0d exp=%0d", emitted_cnt, exp_q.size()); end
        checks++; if (ifc.wr_addr !== m_addr) begin failures++; $display("FAIL rnd_addr got=%h exp=%h", ifc.wr_addr, m_addr); end
        checks++; if (err_obs != exp_err) begin failures++; $display("FAIL rnd_err got=%0d exp=%0d", err_obs, exp_err); end
    endtask

    initial begin
        test_reset();
        test_short_imm();
        test_long_imm();
        test_back_to_back();
        test_wrap_backpressure();
        test_base_collide();
        test_reset_mid();
`ifdef SIK_OPCHECK_EN
        test_opcheck();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sik_encode.md
Name: sik_encode

Overview:
- Instruction encoder for the SIK stack ISA. It is the write-side counterpart of the processor's decode stage.
- Accepts symbolic requests (opcode plus 16-bit immediate) over a valid/ready handshake.
- Packs each request into one or two 16-bit instruction words, inserting a PRE word when the immediate needs more than 12 bits.
- Streams the words to a memory write port at auto-incrementing addresses. Used by the loader and self-test image builder to fill instruction memory.

Parameters:
- ADDR_STEP, 1, address increment per emitted word.
- RESET_ADDR, 16'h0000, write address after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept request this cycle
- in_ext  in  1  1 = extended (no-arg) op, 0 = normal op
- in_op  in  4  opcode nibble
- in_imm  in  16  immediate; ignored when in_ext=1
- base_load  in  1  load write address from base_addr
- base_addr  in  16  new write address
- wr_en  out  1  word valid on wr_addr/wr_data
- wr_addr  out  16  target memory address
- wr_data  out  16  encoded instruction word
- out_ready  in  1  memory accepts word this cycle
- emitted_cnt  out  16  total words written, wraps
- err  out  1  one-cycle illegal-request pulse (SIK_OPCHECK_EN only)

Behaviour:
- Reset (reset=0, async): state=IDLE, wr_en=0, wr_data=0, wr_addr=RESET_ADDR, emitted_cnt=0, err=0. Any pending PRE/op pair is discarded.
- Encoding rules:
  - Extended op: {12'h000, in_op}.
  - Normal op, in_imm[15:12]==0: {in_op, in_imm[11:0]}.
  - Normal op, in_imm[15:12]!=0: PRE word {4'hF, 8'h00, in_imm[15:12]}, then {in_op, in_imm[11:0]}.
- Accept condition: in_valid & in_ready at rising clk.
- States:
  - IDLE: wr_en=0; in_ready=1.
    - Accept, long immediate -> PRE_OUT. wr_data=PRE word; op word is latched internally.
    - Accept, otherwise -> OP_OUT. wr_data=op word.
  - PRE_OUT: wr_en=1; in_ready=0.
    - out_ready=1 -> wr_addr+=ADDR_STEP, emitted_cnt+=1, wr_data=latched op word, go to OP_OUT.
  - OP_OUT: wr_en=1; in_ready=out_ready.
    - out_ready=1 -> wr_addr+=ADDR_STEP, emitted_cnt+=1.
    - Same cycle, if a new request is accepted -> PRE_OUT or OP_OUT by the encoding rules (back-to-back, no bubble). Otherwise -> IDLE.
- Latency: first word is on wr_en in the cycle after accept. Zero-backpressure throughput is 1 word/cycle.
- Backpressure: while wr_en=1 and out_ready=0, wr_addr and wr_data hold stable and no state change occurs.
- base_load:
  - Honoured only in IDLE with no same-cycle accept.
  - If base_load and an accept coincide, the accept wins and base_load is dropped.
  - Ignored in PRE_OUT and OP_OUT.
- Wrap-around: wr_addr wraps modulo 2^16 (16'hFFFF + 1 -> 16'h0000). emitted_cnt wraps the same way.
- A PRE word and its op word always occupy consecutive addresses, even across the wrap.

Optional Feature:
- Macro: SIK_OPCHECK_EN.
- When defined, a request is illegal if any of these holds:
  - in_ext=1 and in_op is 0 or greater than 4'hC.
  - in_ext=0 and in_op is 0, 4'hF, or in 4'h9..4'hE.
- Illegal request handling: the request is still accepted (handshake completes). No word is emitted, state stays IDLE or goes to IDLE, and err=1 for exactly one cycle.
- When undefined: err is tied 0 and all requests are packed raw by the encoding rules.

Decomposition:
- Shared package sik_pkg:
  - normal and extended opcode constants
  - PRE nibble 4'hF
  - NOARG 4'h0
  - word/immediate width constants
  - encoder state encoding (IDLE, PRE_OUT, OP_OUT)
- One natural sub-module: sik_word_pack. Combinational; takes ext/op/imm and produces op_word, pre_word, need_pre and illegal. The FSM, address counter and handshake stay in sik_encode.

Test Plan:
- Reset then push imm=16'h0123 with out_ready=1 -> one cycle later wr_en=1, wr_addr=0, wr_data=16'h8123. Next cycle wr_en=0, emitted_cnt=1.
- push imm=16'hABCD -> wr_data=16'hF00A @0, then 16'h8BCD @1 on consecutive cycles; in_ready=0 during the PRE cycle.
- Back-to-back ext add (op=1) then ext sub (op=3), continuous valid -> 16'h0001 @0, 16'h0003 @1, no idle cycle between them.
- base_load base_addr=16'hFFFF, then a jump with imm=16'h2005 and out_ready held 0 for 3 cycles:
  - wr_data=16'hF002 @16'hFFFF held stable for 3 cycles.
  - Then 16'h6005 @16'h0000.
- Assert reset low during PRE_OUT -> wr_en=0 immediately, wr_addr=0, emitted_cnt=0. The latched op word is never emitted after release.
- With SIK_OPCHECK_EN, ext op=4'hD -> handshake completes, err high exactly 1 cycle, wr_en stays 0, emitted_cnt unchanged.
